// File: rtl/dma_cmd_scheduler.sv
// DMA command scheduler: round-robin intake from NUM_REQ requesters into an in-order
// queue, one command at a time to the engine, completion pulse back to the owner.
module dma_cmd_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_BITS      = 8,
    parameter int SRAM_ADDR_BITS = 11,
    parameter int LEN_BITS       = 8,
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_REQ-1:0]                           req_valid,
    output logic [NUM_REQ-1:0]                           req_ready,
    input  logic [NUM_REQ-1:0]                           req_direction,
    input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]            req_ext_addr,
    input  logic [NUM_REQ-1:0][SRAM_ADDR_BITS-1:0]       req_sram_addr,
    input  logic [NUM_REQ-1:0][LEN_BITS-1:0]             req_length,
    output logic [NUM_REQ-1:0]                           cpl_valid,
    output logic [NUM_REQ-1:0]                           cpl_error,
    output logic                                         dma_cmd_valid,
    output logic                                         dma_cmd_direction,
    output logic [ADDR_BITS-1:0]                         dma_cmd_ext_addr,
    output logic [SRAM_ADDR_BITS-1:0]                    dma_cmd_sram_addr,
    output logic [LEN_BITS-1:0]                          dma_cmd_length,
    input  logic                                         dma_cmd_ready,
    input  logic                                         dma_done,
    input  logic                                         dma_error,
    output logic [$clog2(QUEUE_DEPTH):0]                 queue_count,
    output logic                                         busy,
    output logic [$clog2(NUM_REQ)-1:0]                   active_req_id
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_CPL   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                cpl_err_q, cpl_err_d;
    logic [ID_W-1:0]     act_q, act_d;

    logic [ID_W-1:0]           q_id_q   [QUEUE_DEPTH];
    logic                      q_dir_q  [QUEUE_DEPTH];
    logic [ADDR_BITS-1:0]      q_ext_q  [QUEUE_DEPTH];
    logic [SRAM_ADDR_BITS-1:0] q_sram_q [QUEUE_DEPTH];
    logic [LEN_BITS-1:0]       q_len_q  [QUEUE_DEPTH];

    logic                      arb_found;
    logic [ID_W-1:0]           arb_win;
    logic [ID_W-1:0]           arb_cand;
    logic                      accept;
    logic                      pop;

    logic [ID_W-1:0]           head_id;
    logic                      head_dir;
    logic [ADDR_BITS-1:0]      head_ext;
    logic [SRAM_ADDR_BITS-1:0] head_sram;
    logic [LEN_BITS-1:0]       head_len;

    assign head_id   = q_id_q[rd_ptr_q];
    assign head_dir  = q_dir_q[rd_ptr_q];
    assign head_ext  = q_ext_q[rd_ptr_q];
    assign head_sram = q_sram_q[rd_ptr_q];
    assign head_len  = q_len_q[rd_ptr_q];

    // Round-robin scan starting at rr_ptr; first valid requester wins.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!arb_found && req_valid[arb_cand]) begin
                arb_found = 1'b1;
                arb_win   = arb_cand;
            end
        end
    end

    // Reset gating keeps the grant low while the block is held in reset.
    assign accept = reset && arb_found && (count_q < CNT_W'(QUEUE_DEPTH));

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (arb_win == ID_W'(i));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (arb_win == ID_W'(NUM_REQ - 1)) ? '0 : arb_win + ID_W'(1);
        end
    end

    always_comb begin
        wr_ptr_d = accept ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (accept && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!accept && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            q_id_q[wr_ptr_q]   <= arb_win;
            q_dir_q[wr_ptr_q]  <= req_direction[arb_win];
            q_ext_q[wr_ptr_q]  <= req_ext_addr[arb_win];
            q_sram_q[wr_ptr_q] <= req_sram_addr[arb_win];
            q_len_q[wr_ptr_q]  <= req_length[arb_win];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wd_q      <= '0;
            cpl_err_q <= 1'b0;
            act_q     <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            wd_q      <= wd_d;
            cpl_err_q <= cpl_err_d;
            act_q     <= act_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        cpl_err_d = cpl_err_q;
        wd_d      = wd_q;
        act_d     = act_q;
        case (state_q)
            S_IDLE: begin
                // Zero-length commands complete with error without touching the engine.
                if (count_q != '0) begin
                    if (head_len == '0) begin
                        pop       = 1'b1;
                        act_d     = head_id;
                        cpl_err_d = 1'b1;
                        state_d   = S_CPL;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (dma_cmd_ready) begin
                    pop     = 1'b1;
                    act_d   = head_id;
                    wd_d    = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (dma_done) begin
                    cpl_err_d = dma_error;
                    state_d   = S_CPL;
                end else if ((TIMEOUT_CYCLES != 0) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1))) begin
                    cpl_err_d = 1'b1;
                    state_d   = S_CPL;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_CPL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        dma_cmd_valid     = 1'b0;
        dma_cmd_direction = 1'b0;
        dma_cmd_ext_addr  = '0;
        dma_cmd_sram_addr = '0;
        dma_cmd_length    = '0;
        cpl_valid         = '0;
        cpl_error         = '0;
        case (state_q)
            S_ISSUE: begin
                dma_cmd_valid     = 1'b1;
                dma_cmd_direction = head_dir;
                dma_cmd_ext_addr  = head_ext;
                dma_cmd_sram_addr = head_sram;
                dma_cmd_length    = head_len;
            end
            S_CPL: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (act_q == ID_W'(i)) begin
                        cpl_valid[i] = 1'b1;
                        cpl_error[i] = cpl_err_q;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    assign queue_count   = count_q;
    assign busy          = (state_q != S_IDLE) || (count_q != '0);
    assign active_req_id = act_q;

endmodule

// File: tb/tb_dma_cmd_scheduler.sv
// Randomized and directed bench for dma_cmd_scheduler against a queue-based
// transaction model of the scheduler's rules.
module tb_dma_cmd_scheduler;

    localparam int NR = 2;
    localparam int AB = 8;
    localparam int SB = 11;
    localparam int LB = 8;
    localparam int QD = 4;
    localparam int TO = 16;

    localparam int PH_IDLE  = 0;
    localparam int PH_ISSUE = 1;
    localparam int PH_WAIT  = 2;
    localparam int PH_CPL   = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NR-1:0]         req_valid, req_ready, req_direction, cpl_valid, cpl_error;
    logic [NR-1:0][AB-1:0] req_ext_addr;
    logic [NR-1:0][SB-1:0] req_sram_addr;
    logic [NR-1:0][LB-1:0] req_length;
    logic                  dma_cmd_valid, dma_cmd_direction;
    logic [AB-1:0]         dma_cmd_ext_addr;
    logic [SB-1:0]         dma_cmd_sram_addr;
    logic [LB-1:0]         dma_cmd_length;
    logic                  dma_cmd_ready, dma_done, dma_error;
    logic [$clog2(QD):0]   queue_count;
    logic                  busy;
    logic [$clog2(NR)-1:0] active_req_id;

    dma_cmd_scheduler #(
        .NUM_REQ(NR), .ADDR_BITS(AB), .SRAM_ADDR_BITS(SB), .LEN_BITS(LB),
        .QUEUE_DEPTH(QD), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_direction(req_direction),
        .req_ext_addr(req_ext_addr), .req_sram_addr(req_sram_addr), .req_length(req_length),
        .cpl_valid(cpl_valid), .cpl_error(cpl_error),
        .dma_cmd_valid(dma_cmd_valid), .dma_cmd_direction(dma_cmd_direction),
        .dma_cmd_ext_addr(dma_cmd_ext_addr), .dma_cmd_sram_addr(dma_cmd_sram_addr),
        .dma_cmd_length(dma_cmd_length), .dma_cmd_ready(dma_cmd_ready),
        .dma_done(dma_done), .dma_error(dma_error),
        .queue_count(queue_count), .busy(busy), .active_req_id(active_req_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic          dir;
        logic [AB-1:0] ext;
        logic [SB-1:0] sram;
        logic [LB-1:0] len;
    } cmd_t;

    cmd_t mq[$];
    int   acc_order[$];
    int   m_rr, m_ph, m_wd, m_act;
    logic m_err;
    int   n_vec = 0;
    int   n_err = 0;
    logic [3:0] seen[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        acc_order.delete();
        m_rr  = 0;
        m_ph  = PH_IDLE;
        m_wd  = 0;
        m_act = 0;
        m_err = 1'b0;
    endfunction

    function automatic int m_winner();
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_rr + k) % NR;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_step(input int w);
        bit   do_pop;
        bit   do_push;
        cmd_t c;
        do_pop  = 1'b0;
        do_push = (w >= 0) && (mq.size() < QD);
        case (m_ph)
            PH_IDLE: if (mq.size() > 0) begin
                if (mq[0].len == 0) begin
                    m_act = mq[0].id; m_err = 1'b1; do_pop = 1'b1; m_ph = PH_CPL;
                end else begin
                    m_ph = PH_ISSUE;
                end
            end
            PH_ISSUE: if (dma_cmd_ready) begin
                m_act = mq[0].id; do_pop = 1'b1; m_wd = 0; m_ph = PH_WAIT;
            end
            PH_WAIT: begin
                if (dma_done) begin
                    m_err = dma_error; m_ph = PH_CPL;
                end else if (m_wd == TO - 1) begin
                    m_err = 1'b1; m_ph = PH_CPL;
                end else begin
                    m_wd++;
                end
            end
            default: m_ph = PH_IDLE;
        endcase
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
            c.id = w; c.dir = req_direction[w]; c.ext = req_ext_addr[w];
            c.sram = req_sram_addr[w]; c.len = req_length[w];
            mq.push_back(c);
            acc_order.push_back(w);
            m_rr = (w + 1) % NR;
        end
    endfunction

    task automatic check_outputs(input int w);
        logic [NR-1:0] er, ecv, ece;
        er = '0;
        if (w >= 0 && mq.size() < QD) er[w] = 1'b1;
        check_eq("req_ready", req_ready, er);
        check_eq("cmd_valid", dma_cmd_valid, m_ph == PH_ISSUE);
        if (m_ph == PH_ISSUE) begin
            check_eq("cmd_dir", dma_cmd_direction, mq[0].dir);
            check_eq("cmd_ext", dma_cmd_ext_addr, mq[0].ext);
            check_eq("cmd_sram", dma_cmd_sram_addr, mq[0].sram);
            check_eq("cmd_len", dma_cmd_length, mq[0].len);
            check_eq("cmd_len_nonzero", dma_cmd_length != 0, 1'b1);
        end else begin
            check_eq("cmd_fields_zero",
                     {dma_cmd_direction, dma_cmd_ext_addr, dma_cmd_sram_addr, dma_cmd_length}, 0);
        end
        ecv = '0;
        ece = '0;
        if (m_ph == PH_CPL) begin
            ecv[m_act] = 1'b1;
            ece[m_act] = m_err;
        end
        check_eq("cpl_valid", cpl_valid, ecv);
        check_eq("cpl_error", cpl_error, ece);
        check_eq("queue_count", queue_count, mq.size());
        check_eq("busy", busy, (m_ph != PH_IDLE) || (mq.size() != 0));
        check_eq("active_req_id", active_req_id, m_act);
        if (cpl_valid != '0) begin
            if (acc_order.size() == 0) begin
                check_eq("cpl_order", cpl_valid, 0);
            end else begin
                check_eq("cpl_order", cpl_valid, 1 << acc_order[0]);
                void'(acc_order.pop_front());
            end
        end
    endtask

    // Inputs are changed at the falling edge; outputs are compared 1 time unit later.
    task automatic tick();
        int w;
        #1;
        w = m_winner();
        if (reset) check_outputs(w);
        @(posedge clk);
        if (!reset) model_reset();
        else model_step(w);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic d, input logic [AB-1:0] e,
                           input logic [SB-1:0] s, input logic [LB-1:0] l);
        req_direction[i] = d;
        req_ext_addr[i]  = e;
        req_sram_addr[i] = s;
        req_length[i]    = l;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req_ready"}, req_ready, 0);
        check_eq({tag, "_cpl_valid"}, cpl_valid, 0);
        check_eq({tag, "_cpl_error"}, cpl_error, 0);
        check_eq({tag, "_cmd_valid"}, dma_cmd_valid, 0);
        check_eq({tag, "_cmd_fields"},
                 {dma_cmd_direction, dma_cmd_ext_addr, dma_cmd_sram_addr, dma_cmd_length}, 0);
        check_eq({tag, "_queue_count"}, queue_count, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_active_req_id"}, active_req_id, 0);
    endtask

    task automatic wait_idle();
        int n;
        req_valid = '0; dma_cmd_ready = 1'b1; dma_done = 1'b1; dma_error = 1'b0;
        n = 0;
        while ((busy || queue_count != 0) && n < 200) begin
            tick();
            n++;
        end
        check_eq("idle_bound", busy, 0);
        dma_done = 1'b0;
    endtask

    task automatic collect_cpls(input int cycles, output int n_issue);
        seen.delete();
        n_issue = 0;
        for (int k = 0; k < cycles; k++) begin
            if (dma_cmd_valid) n_issue++;
            if (cpl_valid != '0) seen.push_back({cpl_valid, cpl_error});
            tick();
        end
    endtask

    initial begin
        int n;
        int n_issue;
        req_valid = '0; req_direction = '0; req_ext_addr = '0; req_sram_addr = '0;
        req_length = '0; dma_cmd_ready = 1'b0; dma_done = 1'b0; dma_error = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        req_valid = '1;
        #1 check_all_zero("reset");
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;

        // Single request from requester 0.
        set_req(0, 1'b0, 8'h10, 11'h020, 8'd4);
        req_valid = 2'b01; dma_cmd_ready = 1'b1;
        tick();
        req_valid = '0;
        check_eq("t1_count", queue_count, 1);
        check_eq("t1_cmd_idle", dma_cmd_valid, 0);
        tick();
        check_eq("t1_cmd_valid", dma_cmd_valid, 1);
        check_eq("t1_cmd_ext", dma_cmd_ext_addr, 8'h10);
        check_eq("t1_cmd_sram", dma_cmd_sram_addr, 11'h020);
        check_eq("t1_cmd_len", dma_cmd_length, 4);
        check_eq("t1_cmd_dir", dma_cmd_direction, 0);
        tick();
        repeat (5) tick();
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        check_eq("t1_cpl_valid", cpl_valid, 2'b01);
        check_eq("t1_cpl_error", cpl_error, 2'b00);
        tick();
        check_eq("t1_cpl_once", cpl_valid, 2'b00);
        wait_idle();

        // Both requesters held valid: fill the queue, then drain in order.
        set_req(0, 1'b0, 8'h21, 11'h101, 8'd5);
        set_req(1, 1'b1, 8'h42, 11'h202, 8'd7);
        dma_cmd_ready = 1'b0; dma_done = 1'b0;
        req_valid = 2'b11;
        repeat (8) tick();
        check_eq("t2_full_count", queue_count, 4);
        #1 check_eq("t2_full_ready", req_ready, 2'b00);
        dma_cmd_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            dma_done = (k % 4 == 3);
            tick();
        end
        wait_idle();

        // Zero-length command from requester 1 queued behind a len=8 command.
        dma_done = 1'b0; dma_cmd_ready = 1'b0;
        set_req(0, 1'b0, 8'h33, 11'h033, 8'd8);
        req_valid = 2'b01;
        tick();
        set_req(1, 1'b1, 8'h44, 11'h044, 8'd0);
        req_valid = 2'b10;
        tick();
        req_valid = '0; dma_cmd_ready = 1'b1; dma_done = 1'b1; dma_error = 1'b0;
        collect_cpls(30, n_issue);
        check_eq("t3_issues", n_issue, 1);
        check_eq("t3_ncpl", seen.size(), 2);
        check_eq("t3_cpl0", seen[0], 4'b01_00);
        check_eq("t3_cpl1", seen[1], 4'b10_10);
        wait_idle();

        // Engine error on every transfer; the second command must still issue.
        dma_done = 1'b0; dma_cmd_ready = 1'b0;
        set_req(0, 1'b1, 8'h55, 11'h055, 8'd3);
        req_valid = 2'b01;
        tick();
        set_req(1, 1'b0, 8'h66, 11'h066, 8'd5);
        req_valid = 2'b10;
        tick();
        req_valid = '0; dma_cmd_ready = 1'b1; dma_done = 1'b1; dma_error = 1'b1;
        collect_cpls(30, n_issue);
        check_eq("t4_issues", n_issue, 2);
        check_eq("t4_ncpl", seen.size(), 2);
        check_eq("t4_cpl0", seen[0], 4'b01_01);
        check_eq("t4_cpl1", seen[1], 4'b10_10);
        wait_idle();

        // Watchdog: no dma_done at all.
        dma_done = 1'b0; dma_error = 1'b0; dma_cmd_ready = 1'b1;
        set_req(0, 1'b0, 8'h77, 11'h077, 8'd2);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        n = 0;
        while (!dma_cmd_valid && n < 10) begin
            tick();
            n++;
        end
        check_eq("t5_issue_seen", dma_cmd_valid, 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (cpl_valid == '0 && n < 40);
        check_eq("t5_latency", n, TO + 1);
        check_eq("t5_cpl_error", cpl_error, 2'b01);
        tick();
        dma_done = 1'b1; dma_error = 1'b1;
        repeat (3) begin
            tick();
            check_eq("t5_spurious_cpl", cpl_valid, 0);
        end
        check_eq("t5_spurious_busy", busy, 0);
        dma_done = 1'b0; dma_error = 1'b0;

        // Randomized traffic.
        for (int k = 0; k < 2000; k++) begin
            req_valid = NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                set_req(i, 1'($urandom), AB'($urandom), SB'($urandom),
                        ($urandom_range(0, 5) == 0) ? LB'(0) : LB'($urandom_range(1, 255)));
            end
            dma_cmd_ready = 1'($urandom_range(0, 1));
            dma_done      = ($urandom_range(0, 3) == 0);
            dma_error     = ($urandom_range(0, 2) == 0);
            tick();
        end
        wait_idle();

        // Asynchronous reset while in WAIT with two entries queued.
        dma_done = 1'b0; dma_error = 1'b0; dma_cmd_ready = 1'b1;
        set_req(0, 1'b0, 8'h81, 11'h081, 8'd9);
        set_req(1, 1'b1, 8'h92, 11'h092, 8'd6);
        req_valid = 2'b11;
        n = 0;
        while (!(m_ph == PH_WAIT && mq.size() == 2) && n < 20) begin
            tick();
            n++;
        end
        check_eq("t7_reach_count", queue_count, 2);
        check_eq("t7_reach_busy", busy, 1);
        #2 reset = 1'b0;
        #1 check_all_zero("rst_async");
        @(negedge clk);
        check_all_zero("rst_held");
        model_reset();
        req_valid = '0;
        reset = 1'b1;
        dma_done = 1'b1;
        repeat (6) tick();
        check_eq("rst_count_after", queue_count, 0);
        check_eq("rst_no_cpl", cpl_valid, 0);
        dma_done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
